// File: rtl/disp_pkg.sv
// Shared types and constants for the four-digit 7-segment scanner.
package disp_pkg;

    localparam int NDIG  = 4;
    localparam int NIB_W = 4;
    localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // True when nibbles d..NDIG-1 of val are all zero.
    function automatic logic lead_zero(input logic [NDIG*NIB_W-1:0] val, input logic [1:0] d);
        logic z;
        z = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (i >= int'(d) && val[i*NIB_W +: NIB_W] != '0)
                z = 1'b0;
        end
        return z;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot counter: wraps every SCAN_DIV cycles, flags the end of blanking and of the slot.
module scan_prescaler #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_end,
    output logic slot_end
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;

    // Both pulses mark the cycle before the edge on which the change takes effect.
    assign blank_end = (cnt == CW'(BLANK_CYC - 1));
    assign slot_end  = (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (slot_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/disp_scan4.sv
// Four-digit common-anode scanner with blanking gaps and frame-synchronous double buffering.
// Optional leading-zero suppression when DISP_SCAN4_LZ_BLANK_EN is defined.
import disp_pkg::*;

module disp_scan4 #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data,
    output logic [3:0]  bcd,
    output logic        en,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int DW = NDIG * NIB_W;

    logic          blank_end, slot_end, boundary, lz;
    state_t        state, state_nx;
    logic [1:0]    digit, digit_nx;
    logic [DW-1:0] shadow, active, active_nx;
    logic          pending;

    scan_prescaler #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_pre (
        .clk       (clk),
        .rst_n     (rst_n),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    assign boundary = slot_end && (digit == 2'(NDIG - 1));

    always_comb begin
        state_nx = state;
        if (slot_end)
            state_nx = ST_BLANK;
        else if (blank_end)
            state_nx = ST_SHOW;
        digit_nx  = slot_end ? digit + 2'd1 : digit;
        // Commit reads the pre-edge shadow, so a same-edge load stays pending.
        active_nx = (boundary && pending) ? shadow : active;
    end

`ifdef DISP_SCAN4_LZ_BLANK_EN
    assign lz = (digit_nx != 2'd0) && lead_zero(active_nx, digit_nx);
`else
    assign lz = 1'b0;
`endif

    // Outputs come from next-state values so they switch on the same edge as state/digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_BLANK;
            digit   <= '0;
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            bcd     <= '0;
            en      <= 1'b0;
            an      <= AN_OFF;
            frame   <= 1'b0;
        end else begin
            state  <= state_nx;
            digit  <= digit_nx;
            active <= active_nx;
            if (load) begin
                shadow  <= data;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            bcd   <= active_nx[digit_nx*NIB_W +: NIB_W];
            en    <= (state_nx == ST_SHOW) && !lz;
            an    <= (state_nx == ST_SHOW) ? ~(NDIG'(1) << digit_nx) : AN_OFF;
            frame <= boundary;
        end
    end

endmodule

// File: tb/tb_disp_scan4.sv
// Directed bench for disp_scan4 with a cycle-indexed reference model checked every cycle.
module tb_disp_scan4;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * SD;
`ifdef DISP_SCAN4_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  bcd, an;
    logic        en, frame;

    int checks = 0;
    int errors = 0;

    disp_scan4 #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (data),
        .bcd   (bcd),
        .en    (en),
        .an    (an),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: t = cycles since reset release; display content follows from t alone.
    int          t;
    logic [15:0] m_shadow, m_active;
    bit          m_pending, m_frame;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= 0; m_shadow <= '0; m_active <= '0; m_pending <= 1'b0; m_frame <= 1'b0;
        end else begin
            t       <= t + 1;
            m_frame <= ((t + 1) % FR == 0);
            if (((t + 1) % FR == 0) && m_pending) m_active <= m_shadow;
            if (load) begin
                m_shadow  <= data;
                m_pending <= 1'b1;
            end else if ((t + 1) % FR == 0) begin
                m_pending <= 1'b0;
            end
        end
    end

    function automatic logic [3:0] f_an(input int tt);
        int d = (tt / SD) % 4;
        return ((tt % SD) >= BC) ? ~(4'b0001 << d) : 4'hF;
    endfunction

    function automatic logic f_en(input int tt, input logic [15:0] act);
        int d = (tt / SD) % 4;
        return ((tt % SD) >= BC) && (!LZ || d == 0 || (act >> (4 * d)) != 16'h0);
    endfunction

    function automatic logic [3:0] f_bcd(input int tt, input logic [15:0] act);
        int d = (tt / SD) % 4;
        return act[4*d +: 4];
    endfunction

    int last_fr = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_an", 16'(an), 16'hF);
            chk("rst_en", 16'(en), 16'h0);
            chk("rst_frame", 16'(frame), 16'h0);
            last_fr <= -1;
        end else begin
            chk("m_an", 16'(an), 16'(f_an(t)));
            chk("m_en", 16'(en), 16'(f_en(t, m_active)));
            chk("m_bcd", 16'(bcd), 16'(f_bcd(t, m_active)));
            chk("m_frame", 16'(frame), 16'(m_frame));
            chk("one_anode", 16'($countones(~an) <= 1), 16'h1);
            if (frame) begin
                if (last_fr >= 0) chk("frame_gap", 16'(t - last_fr), 16'(FR));
                last_fr <= t;
            end
        end
    end

    int cyc;
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; cyc++; end
    endtask
    task automatic go(input int c);
        step(c - cyc);
    endtask
    task automatic pulse_load(input logic [15:0] v);
        load = 1'b1; data = v; step(1); load = 1'b0;
    endtask
    task automatic see(input string name, input logic [3:0] e_an, input logic e_en, input logic [3:0] e_bcd);
        chk({name, "_an"}, 16'(an), 16'(e_an));
        chk({name, "_en"}, 16'(en), 16'(e_en));
        chk({name, "_bcd"}, 16'(bcd), 16'(e_bcd));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;

        // Power-up scan with nothing loaded
        see("c0", 4'hF, 1'b0, 4'h0);
        chk("c0_frame", 16'(frame), 16'h0);
        go(1);  see("c1", 4'hF, 1'b0, 4'h0);
        go(2);  see("c2", 4'hE, 1'b1, 4'h0);
        go(5);  pulse_load(16'h1234);
        go(7);  see("c7", 4'hE, 1'b1, 4'h0);
        go(31); chk("c31_frame", 16'(frame), 16'h0);
        go(32); chk("c32_frame", 16'(frame), 16'h1);
        see("c32", 4'hF, 1'b0, 4'h4);
        go(34); see("d0", 4'hE, 1'b1, 4'h4);
        go(42); see("d1", 4'hD, 1'b1, 4'h3);
        go(50); see("d2", 4'hB, 1'b1, 4'h2);
        go(58); see("d3", 4'h7, 1'b1, 4'h1);

        // Load on the frame edge while another value is pending
        go(70); pulse_load(16'h5555);
        go(95); pulse_load(16'hAAAA);
        chk("c96_frame", 16'(frame), 16'h1);
        go(98);  see("f5_d0", 4'hE, 1'b1, 4'h5);
        go(122); see("f5_d3", 4'h7, 1'b1, 4'h5);
        go(130); see("fA_d0", 4'hE, 1'b1, 4'hA);

        // Asynchronous reset during digit 2 SHOW
        go(148); see("pre_rst", 4'hB, 1'b1, 4'hA);
        #2 rst_n = 1'b0;
        #1 see("async_rst", 4'hF, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        go(2); see("post_rst", 4'hE, 1'b1, 4'h0);

        // Leading-zero patterns
        go(3);  pulse_load(16'h0050);
        go(34); see("z50_d0", 4'hE, 1'b1, 4'h0);
        go(40); pulse_load(16'h0000);
        go(42); see("z50_d1", 4'hD, 1'b1, 4'h5);
        go(50); see("z50_d2", 4'hB, !LZ, 4'h0);
        go(58); see("z50_d3", 4'h7, !LZ, 4'h0);
        go(66); see("z00_d0", 4'hE, 1'b1, 4'h0);
        go(74); see("z00_d1", 4'hD, !LZ, 4'h0);
        go(82); see("z00_d2", 4'hB, !LZ, 4'h0);
        go(90); see("z00_d3", 4'h7, !LZ, 4'h0);
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan4.md
Name: disp_scan4

Overview:
- Upstream feeder for the 7-segment decoder: time-multiplexes a 16-bit hex value across four common-anode digits.
- Drives the decoder's `bcd` nibble and `en`, plus the per-digit anode selects.
- Inserts a blanking gap between digits to suppress ghosting.
- Double-buffers the displayed value so a new load never tears a frame.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (blank + show); legal range 4..2^20
BLANK_CYC, 500, cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; captures data into shadow register
data  in  16  hex value; data[3:0] = digit 0 (rightmost) .. data[15:12] = digit 3
bcd  out  4  nibble for the decoder
en  out  1  decoder enable; 0 forces segments off
an  out  4  anode selects, active-low, one-hot-low during SHOW, 4'b1111 otherwise
frame  out  1  one-cycle strobe on the first cycle of each frame (digit 0 BLANK entry)

Behaviour:
- Reset is asynchronous and active-low; there is one clock. Reset state:
  - cnt=0, digit=0, state=BLANK, shadow=0, active=0, pending=0
  - bcd=4'h0, en=0, an=4'b1111, frame=0
- All outputs are registered and change on the same edge as state/digit, so they are never a cycle stale.
- Slot counter `cnt` counts 0..SCAN_DIV-1 and wraps to 0. Each slot belongs to the current digit.
- FSM, two states:
  - BLANK, while cnt < BLANK_CYC:
    - an=4'b1111, en=0; bcd holds the current digit's nibble.
    - Moves to SHOW on the edge where cnt becomes BLANK_CYC.
  - SHOW, while cnt >= BLANK_CYC:
    - an[digit]=0, others 1; en=1; bcd=active[4*digit+:4].
    - On the edge where cnt wraps SCAN_DIV-1 -> 0: digit increments mod 4 and state returns to BLANK.
- Frame boundary, on the edge where digit wraps 3 -> 0:
  - If pending=1: active <= shadow, pending <= 0.
  - frame=1 during that first cycle of digit 0 BLANK, 0 otherwise.
- Load handling:
  - load=1 gives shadow <= data and pending <= 1 on that edge.
  - Back-to-back loads: last one wins.
- Simultaneous load and frame boundary on the same edge:
  - active takes the OLD shadow; shadow takes the new data; pending stays 1.
  - The new value is committed at the next frame.
- Reset mid-slot returns immediately to the reset state (anodes off within the reset assertion, not at the next clock).
- Frame period is exactly 4*SCAN_DIV cycles. Each digit shows for SCAN_DIV-BLANK_CYC cycles per frame.

Optional Feature:
- Macro: DISP_SCAN4_LZ_BLANK_EN.
- Defined: leading-zero suppression. During SHOW of digit d (d=3,2,1), en=0 if active nibbles d..3 are all zero. an still asserts as normal. Digit 0 is never suppressed, so 16'h0000 shows "0" and 16'h0050 shows "50".
- Undefined: en=1 in every SHOW slot; all four digits display, including zeros.

Decomposition:
- Shared package disp_pkg holds:
  - state encoding (ST_BLANK=1'b0, ST_SHOW=1'b1)
  - NDIG=4 and NIB_W=4
  - AN_OFF=4'b1111
- Sub-module: scan_prescaler, holding the SCAN_DIV counter and producing blank_end and slot_end pulses. All remaining logic stays in the top.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, macro undefined unless stated):
- Reset hold then release, no load -> an=4'b1111 and en=0 for cycles 0-1; then an=4'b1110, en=1, bcd=0 for cycles 2-7; frame=1 at cycle 32.
- load with data=16'h1234 at cycle 5 -> frame 0 shows 0,0,0,0. From cycle 32, the SHOW slots show bcd 4,3,2,1 with an 1110,1101,1011,0111.
- load 16'hAAAA on the exact cycle frame boundary occurs, with pending 16'h5555 -> next frame shows 5s; the following frame shows As.
- Assert rst_n=0 mid-SHOW of digit 2 -> an=4'b1111 and en=0 asynchronously; after release, scan restarts at digit 0 BLANK with active=0.
- Macro defined, load 16'h0050 -> digits 3,2 give en=0 with anodes asserted; digits 1,0 give en=1 with bcd 5,0. Load 16'h0000 -> only digit 0 has en=1, with bcd=0.
- Check every frame -> exactly 32 cycles between frame pulses; never two anodes low at once; an=4'b1111 whenever en=0 in BLANK.
